// File: rtl/accel_postproc_if.sv
// Handshake and job-configuration bundle between the accelerator core, the
// post-processing stage and the output BRAM write port.
interface accel_postproc_if #(
  parameter int ACCUM_WIDTH = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 11
);
  logic                    start;
  logic [ADDR_WIDTH:0]     num_outputs;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    bank_sel;
  logic [1:0]              act_sel;
  logic [DATA_WIDTH-1:0]   bias;
  logic                    acc_valid;
  logic [ACCUM_WIDTH-1:0]  acc_data;
  logic                    acc_ready;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [4:0]              wr_bank;
  logic                    out_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start, num_outputs, base_addr, bank_sel, act_sel, bias,
           acc_valid, acc_data, out_ready,
    input  acc_ready, wr_en, wr_addr, wr_data, wr_bank, busy, done
  );

  modport slave (
    input  start, num_outputs, base_addr, bank_sel, act_sel, bias,
           acc_valid, acc_data, out_ready,
    output acc_ready, wr_en, wr_addr, wr_data, wr_bank, busy, done
  );
endinterface

// File: rtl/accel_postproc.sv
// Output post-processing: rescale, bias, saturate to Q4.4, activate, and
// write each result to an output ping-pong bank at sequential addresses.
module accel_postproc #(
  parameter int ACCUM_WIDTH = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int SHIFT       = 4
) (
  input logic             clk,
  input logic             rst_n,
  accel_postproc_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam int SUM_W     = ACCUM_WIDTH + 1;
  localparam int SAT_MAX_I = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SAT_MAX_I[SUM_W-1:0];
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [ADDR_WIDTH:0]     CNT_ONE = (ADDR_WIDTH + 1)'(1);
  // tanh approximation knees, in Q4.4 magnitude units
  localparam logic [DATA_WIDTH:0]     TANH_LIN  = (DATA_WIDTH + 1)'(8);
  localparam logic [DATA_WIDTH:0]     TANH_KNEE = (DATA_WIDTH + 1)'(40);
  localparam logic [DATA_WIDTH-1:0]   TANH_BASE = DATA_WIDTH'(8);
  localparam logic [DATA_WIDTH-1:0]   TANH_MAX  = DATA_WIDTH'(16);

  state_t                    r_state, w_state_next;
  logic [ADDR_WIDTH:0]       r_num, r_in_count, r_out_count, w_written_next;
  logic [ADDR_WIDTH-1:0]     r_base;
  logic                      r_bank_sel;
  logic [1:0]                r_act;

  logic                      r_s1_valid, r_s2_valid;
  logic signed [SUM_W-1:0]   r_s1_sum;
  logic [ADDR_WIDTH-1:0]     r_s1_addr, r_s2_addr;
  logic [DATA_WIDTH-1:0]     r_s2_data;

  logic                      w_advance, w_acc_ready, w_accept, w_write, w_start;
  logic signed [ACCUM_WIDTH-1:0] w_sh;
  logic signed [SUM_W-1:0]   w_sum;
  logic [DATA_WIDTH-1:0]     w_sat, w_mag, w_act;
  logic [DATA_WIDTH:0]       w_abs, w_seg;

  assign w_start     = (r_state == S_IDLE) && bus.start;
  assign w_advance   = !r_s2_valid || bus.out_ready;
  assign w_acc_ready = (r_state == S_RUN) && w_advance && (r_in_count < r_num);
  assign w_accept    = bus.acc_valid && w_acc_ready;
  assign w_write     = r_s2_valid && bus.out_ready;
  assign w_written_next = r_out_count + (w_write ? CNT_ONE : '0);

  // Stage 1 arithmetic: the 17-bit sum holds any shifted value plus bias.
  assign w_sh  = $signed(bus.acc_data) >>> SHIFT;
  assign w_sum = {w_sh[ACCUM_WIDTH-1], w_sh}
               + {{(SUM_W - DATA_WIDTH){bus.bias[DATA_WIDTH-1]}}, bus.bias};

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sat = r_s1_sum[DATA_WIDTH-1:0];
    if (r_s1_sum > SAT_MAX)      w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (r_s1_sum < SAT_MIN) w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    w_abs = w_sat[DATA_WIDTH-1] ? -{1'b1, w_sat} : {1'b0, w_sat};
    w_seg = w_abs - TANH_LIN;
    w_mag = TANH_MAX;
    if (w_abs < TANH_LIN)       w_mag = w_abs[DATA_WIDTH-1:0];
    else if (w_abs < TANH_KNEE) w_mag = TANH_BASE + DATA_WIDTH'(w_seg >> 2);

    w_act = w_sat;
    case (r_act)
      2'd1:    w_act = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
      2'd2:    w_act = w_sat[DATA_WIDTH-1] ? -w_mag : w_mag;
      default: w_act = w_sat;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = (bus.num_outputs == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_accept && (r_in_count + CNT_ONE == r_num)) w_state_next = S_FLUSH;
      S_FLUSH: if (w_written_next == r_num) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num       <= '0;
      r_base      <= '0;
      r_bank_sel  <= 1'b0;
      r_act       <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
    end else if (w_start) begin
      r_num       <= bus.num_outputs;
      r_base      <= bus.base_addr;
      r_bank_sel  <= bus.bank_sel;
      r_act       <= bus.act_sel;
      r_in_count  <= '0;
      r_out_count <= '0;
    end else begin
      if (w_accept) r_in_count  <= r_in_count + CNT_ONE;
      if (w_write)  r_out_count <= r_out_count + CNT_ONE;
    end
  end

  // Both stages move together; when S2 is stalled the whole pipe holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_addr  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      if (w_accept) begin
        r_s1_sum  <= w_sum;
        r_s1_addr <= r_base + r_in_count[ADDR_WIDTH-1:0];
      end
      if (r_s1_valid) begin
        r_s2_data <= w_act;
        r_s2_addr <= r_s1_addr;
      end
    end
  end

  assign bus.acc_ready = w_acc_ready;
  assign bus.wr_en     = r_s2_valid;
  assign bus.wr_addr   = r_s2_addr;
  assign bus.wr_data   = r_s2_data;
  assign bus.wr_bank   = r_bank_sel ? 5'd3 : 5'd2;
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_accel_postproc.sv
// Randomized bench for accel_postproc: a behavioural model predicts every
// write (address, data, bank) and the done pulse; a compare process checks them.
module tb_accel_postproc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accel_postproc_if #(.ACCUM_WIDTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(11)) bus ();

  accel_postproc #(.ACCUM_WIDTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(11), .SHIFT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    logic [4:0]  bank;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] stim_acc[$];
  logic [7:0]  stim_bias[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;
  bit zero_pending = 1'b0;
  bit pend_done = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: Q8.8 -> Q4.4 rescale, bias, clamp, activation in plain integers.
  function automatic logic [7:0] model(input logic [15:0] acc, input logic [7:0] b, input int act);
    int sh, s, sat, a, m, y;
    sh  = int'($signed(acc)) >>> 4;
    s   = sh + int'($signed(b));
    sat = (s > 127) ? 127 : ((s < -128) ? -128 : s);
    case (act)
      1: y = (sat < 0) ? 0 : sat;
      2: begin
        a = (sat < 0) ? -sat : sat;
        if (a < 8)       m = a;
        else if (a < 40) m = 8 + (a - 8) / 4;
        else             m = 16;
        y = (sat < 0) ? -m : m;
      end
      default: y = sat;
    endcase
    return y[7:0];
  endfunction

  task automatic add(input logic [15:0] a, input logic [7:0] b);
    stim_acc.push_back(a);
    stim_bias.push_back(b);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend_done = 1'b0;
    end else begin
      check("done", bus.done, pend_done || zero_pending);
      if (bus.done) begin
        done_count++;
        check("busy_at_done", bus.busy, 0);
      end
      pend_done = 1'b0;
      if (bus.wr_en && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
          check("wr_bank", bus.wr_bank, e.bank);
          pend_done = e.last;
        end
      end
    end
  end

  function automatic logic pick_ready(input bit rand_bp);
    return rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  task automatic run_job(input int n, input int base, input bit bank, input int act,
                         input bit rand_valid, input bit rand_bp,
                         input int bp_start, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int dc0;
    exp_t e;
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.num_outputs = 12'(n);
    bus.base_addr   = 11'(base);
    bus.bank_sel    = bank;
    bus.act_sel     = 2'(act);
    bus.out_ready   = 1'b1;
    dc0 = done_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (n == 0) begin
      zero_pending = 1'b1;
      @(posedge clk); #1;
      zero_pending = 1'b0;
    end else begin
      while (idx < n && cyc < 2000) begin
        bus.acc_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.acc_data  = stim_acc[idx];
        bus.bias      = stim_bias[idx];
        if (bp_start >= 0 && cyc >= bp_start && cyc < bp_start + 5) bus.out_ready = 1'b0;
        else bus.out_ready = pick_ready(rand_bp);
        @(negedge clk);
        if (cyc == 0) check("busy_in_run", bus.busy, 1);
        if (bp_start >= 0 && cyc == bp_start + 4) check("acc_ready_stalled", bus.acc_ready, 0);
        if (bus.acc_valid && bus.acc_ready) begin
          e.addr = 11'(base + idx);
          e.data = model(stim_acc[idx], stim_bias[idx], act);
          e.bank = bank ? 5'd3 : 5'd2;
          e.last = (idx == n - 1);
          exp_q.push_back(e);
          idx++;
        end
        @(posedge clk); #1;
        cyc++;
        if (cyc == abort_at) begin
          #1 rst_n = 1'b0;
          #1;
          check("rst_acc_ready", bus.acc_ready, 0);
          check("rst_wr_en", bus.wr_en, 0);
          check("rst_busy", bus.busy, 0);
          check("rst_done", bus.done, 0);
          check("rst_wr_addr", bus.wr_addr, 0);
          check("rst_wr_data", bus.wr_data, 0);
          check("rst_wr_bank", bus.wr_bank, 2);
          exp_q.delete();
          bus.acc_valid = 1'b0;
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          stim_acc.delete();
          stim_bias.delete();
          return;
        end
      end
      check("accepted_all", idx, n);
      // Keep offering data: a finished job must not take another result.
      bus.acc_valid = 1'b1;
      bus.acc_data  = 16'h1234;
      for (int h = 0; h < 2; h++) begin
        bus.out_ready = pick_ready(rand_bp);
        @(negedge clk);
        check("acc_ready_after_last", bus.acc_ready, 0);
        if (n == 1 && !rand_valid && !rand_bp) check("latency_wr_en", bus.wr_en, (h == 1));
        @(posedge clk); #1;
      end
      bus.acc_valid = 1'b0;
      cyc = 0;
      while (done_count == dc0 && cyc < 3000) begin
        bus.out_ready = pick_ready(rand_bp);
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("job_done_once", done_count - dc0, 1);
    check("queue_drained", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    stim_acc.delete();
    stim_bias.delete();
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.num_outputs = '0; bus.base_addr = '0; bus.bank_sel = 1'b0;
    bus.act_sel = '0; bus.bias = '0; bus.acc_valid = 1'b0; bus.acc_data = '0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_acc_ready", bus.acc_ready, 0);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_wr_addr", bus.wr_addr, 0);
    check("reset_wr_data", bus.wr_data, 0);
    check("reset_wr_bank", bus.wr_bank, 2);
    @(negedge clk);
    rst_n = 1'b1;

    check("model_basic",    model(16'h0123, 8'h00, 0), 8'h12);
    check("model_sat_hi",   model(16'h7FFF, 8'h00, 0), 8'h7F);
    check("model_sat_lo",   model(16'h8000, 8'h00, 0), 8'h80);
    check("model_bias_sat", model(16'h07F0, 8'h10, 0), 8'h7F);
    check("model_bias_neg", model(16'hFFF0, 8'h10, 0), 8'h0F);
    check("model_relu",     model(16'hFFF0, 8'h00, 1), 8'h00);
    check("model_tanh_lin", model(16'h0040, 8'h00, 2), 8'h04);
    check("model_tanh_mid", model(16'h0180, 8'h00, 2), 8'h0C);
    check("model_tanh_top", model(16'h0600, 8'h00, 2), 8'h10);
    check("model_tanh_neg", model(16'hFE80, 8'h00, 2), 8'hF4);

    add(16'h0123, 8'h00);
    run_job(1, 11'h010, 1'b0, 0, 1'b0, 1'b0, -1, -1);

    add(16'h7FFF, 8'h00); add(16'h8000, 8'h00); add(16'h07F0, 8'h10); add(16'hFFF0, 8'h10);
    run_job(4, 11'h020, 1'b0, 0, 1'b0, 1'b0, -1, -1);

    add(16'hFFF0, 8'h00); add(16'h0040, 8'h00);
    run_job(2, 11'h030, 1'b0, 1, 1'b0, 1'b0, -1, -1);

    add(16'h0040, 8'h00); add(16'h0180, 8'h00); add(16'h0600, 8'h00); add(16'hFE80, 8'h00);
    run_job(4, 11'h040, 1'b1, 2, 1'b0, 1'b0, -1, -1);

    for (int i = 0; i < 4; i++) add(16'(16'h0100 + 16'(i) * 16'h0110), 8'h00);
    run_job(4, 11'h050, 1'b0, 0, 1'b0, 1'b0, 2, -1);

    for (int i = 0; i < 3; i++) add(16'(16'h0200 + 16'(i) * 16'h0010), 8'h00);
    run_job(3, 11'h7FE, 1'b1, 0, 1'b0, 1'b0, -1, -1);

    run_job(0, 11'h100, 1'b0, 0, 1'b0, 1'b0, -1, -1);

    for (int i = 0; i < 8; i++) add(16'(16'h0100 * (i + 1)), 8'h01);
    run_job(8, 11'h100, 1'b1, 0, 1'b0, 1'b0, -1, 5);

    add(16'h0123, 8'h00); add(16'hFE80, 8'h00);
    run_job(2, 11'h200, 1'b0, 2, 1'b0, 1'b0, -1, -1);

    for (int j = 0; j < 8; j++) begin
      n = (j == 0) ? 200 : $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) add(16'($urandom), 8'($urandom));
        else add(16'($urandom_range(0, 2047)) - 16'd1024, 8'($urandom_range(0, 63)) - 8'd32);
      end
      run_job(n, (j == 1) ? 2040 : $urandom_range(0, 2047), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'b1, 1'b1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accel_postproc.md
Name: accel_postproc

Overview:
- Output post-processing stage between the MAC/accumulator datapath and the output ping-pong BRAM banks.
- Consumes a stream of signed ACCUM_WIDTH accumulator results and rescales each one (arithmetic shift), adds an 8-bit Q4.4 bias, saturates to Q4.4 and applies the selected activation.
- Emits one BRAM write per result into BANK_OUTPUT_0 or BANK_OUTPUT_1 at sequential addresses.
- Shared by the MLP, CNN and RNN accelerators; job-based: start, stream N results, done.

Parameters:
- ACCUM_WIDTH, 16, accumulator input width (signed).
- DATA_WIDTH, 8, output width, Q4.4 signed.
- ADDR_WIDTH, 11, BRAM word address width (2048 words).
- SHIFT, 4, arithmetic right shift that converts a Q8.8 product sum to Q4.4.

Ports:
- clk  in  1  Clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- start  in  1  Job start pulse. Accepted only in IDLE.
- num_outputs  in  ADDR_WIDTH+1  Number of results in the job, 0..2048. Latched on start.
- base_addr  in  ADDR_WIDTH  First write address. Latched on start.
- bank_sel  in  1  0 selects BANK_OUTPUT_0 (bank 2), 1 selects BANK_OUTPUT_1 (bank 3). Latched on start.
- act_sel  in  2  Activation: 0 none, 1 ReLU, 2 tanh, 3 treated as none. Latched on start.
- bias  in  DATA_WIDTH  Signed Q4.4 bias. Sampled with each accepted result.
- acc_valid  in  1  Accumulator result valid.
- acc_data  in  ACCUM_WIDTH  Signed accumulator result.
- acc_ready  out  1  Stage accepts acc_data this cycle.
- wr_en  out  1  Output write strobe.
- wr_addr  out  ADDR_WIDTH  Write address.
- wr_data  out  DATA_WIDTH  Q4.4 result.
- wr_bank  out  5  Bank index, 5'd2 or 5'd3.
- out_ready  in  1  Write sink accepts; the write completes on wr_en && out_ready.
- busy  out  1  High in RUN and FLUSH.
- done  out  1  One-cycle pulse when the job completes.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all counters and pipeline valids cleared.
  - acc_ready, wr_en, busy, done = 0; wr_addr, wr_data = 0; wr_bank = 5'd2.
  - Reset mid-job abandons the job silently; no done is issued.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start with num_outputs != 0. Config is latched and the in/out counters are cleared.
  - IDLE -> DONE on start with num_outputs == 0.
  - RUN -> FLUSH on the cycle the accepted-count reaches num_outputs.
  - FLUSH -> DONE when the written-count equals num_outputs.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- Pipeline: two registered stages, S1 then S2, with S2 driving the outputs.
  - advance = !s2_valid || out_ready.
  - acc_ready = (state==RUN) && advance && (in_count < num_outputs). acc_ready is 0 in IDLE, FLUSH and DONE.
  - Transfer occurs on acc_valid && acc_ready.
  - When advance=0, all stages hold and no data is lost or duplicated.
- Latency: a result accepted at edge N appears with wr_en=1 in the cycle after edge N+1 (two registers). Full throughput is one result per cycle.
- S1 (rescale and bias):
  - sh = acc_data >>> SHIFT (arithmetic).
  - sum = sext17(sh) + sext17(bias).
  - sum is held in 17 bits, so it cannot overflow.
- S2 (saturate):
  - sat = 127 if sum > 127; -128 if sum < -128; otherwise sum[7:0].
- S2 (activation):
  - none: y = sat.
  - ReLU: y = 0 if sat < 0, else sat.
  - tanh: a = |sat| held in 9 bits (so -128 gives 128).
    - a < 8: m = a.
    - 8 <= a < 40: m = 8 + ((a-8)>>2).
    - a >= 40: m = 16.
    - y = m with the sign of sat reapplied (negative gives -m).
  - tanh output range is [-16, +16].
- Address: wr_addr = (base_addr + out_index) mod 2^ADDR_WIDTH, where out_index is the result's position in the job. The address wraps past 0x7FF to 0x000.
- wr_bank = bank_sel ? 5'd3 : 5'd2, constant for the whole job.
- written-count increments on wr_en && out_ready.
- done is asserted only after the final write completes.

Test Plan:
- Basic: act=none, bias=0, base=0x010, N=1, acc=0x0123 -> wr_data=0x12, wr_addr=0x010, wr_bank=2, wr_en exactly 2 cycles after accept; done the cycle after the write.
- Saturation, bias=0: acc=0x7FFF -> 0x7F; acc=0x8000 -> 0x80. With bias=0x10: acc=0x07F0 -> 0x7F; acc=0xFFF0 -> 0x0F.
- Activations, all with bias=0:
  - ReLU: acc=0xFFF0 -> 0x00.
  - tanh: acc=0x0040 -> 0x04.
  - tanh: acc=0x0180 -> 0x0C.
  - tanh: acc=0x0600 -> 0x10.
  - tanh: acc=0xFE80 -> 0xF4.
- Backpressure: N=4 back-to-back, out_ready=0 for 5 cycles mid-stream -> acc_ready drops, 4 writes in order with no loss or duplicates, done once.
- Wrap and bank: N=3, base=0x7FE, bank_sel=1 -> writes to 0x7FE, 0x7FF, 0x000 on bank 3. acc_ready=0 after the 3rd accept. A 4th acc_valid is not consumed.
- Edge cases:
  - N=0 -> done pulses the cycle after start, no writes.
  - rst_n low mid-job -> all outputs go to reset values immediately; a new start afterwards runs normally.
